// File: rtl/data_sram_responder_if.sv
// Data-SRAM request/response bundle: req/addr_ok accept a request, data_ok/rdata return it.
// Valid/ready: a transfer happens at the rising edge where req && addr_ok; data_ok is a one-cycle pulse with rdata.
interface data_sram_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Word-addressed data-SRAM responder with an in-order response queue of DEPTH entries.
// Optional macro DATA_SRAM_RANDOM_DELAY_EN adds 0..3 LFSR-chosen cycles to each response.
module data_sram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_sram_responder_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 3;
`ifdef DATA_SRAM_RANDOM_DELAY_EN
  localparam int CD_W  = 4;
`else
  localparam int CD_W  = 3;
`endif

  typedef struct packed {
    logic            is_read;
    logic [31:0]     data;
    logic [CD_W-1:0] cd;
  } entry_t;

  logic [31:0]            mem [2**ADDR_WIDTH];

  entry_t                 q_q   [DEPTH];
  entry_t                 q_d   [DEPTH];
  logic [DEPTH-1:0]       vld_q, vld_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic                   accept;
  logic                   pop;
  logic [ADDR_WIDTH-1:0]  idx;
  logic [31:0]            rd_word;
  logic [CD_W-1:0]        init_cd;
  entry_t                 head_e;
  logic                   unused_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign idx         = bus.addr[ADDR_WIDTH+1:2];
  assign rd_word     = mem[idx];
  assign unused_bits = ^{bus.size, bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};

  // No retire-then-accept bypass: a full queue stalls even while data_ok fires.
  assign bus.addr_ok = !reset && (count_q < CNT_W'(DEPTH));
  assign accept      = bus.req && bus.addr_ok;

  assign head_e      = q_q[head_q];
  assign pop         = !reset && vld_q[head_q] && (head_e.cd == '0);
  assign bus.data_ok = pop;
  assign bus.rdata   = (pop && head_e.is_read) ? head_e.data : 32'h0;

`ifdef DATA_SRAM_RANDOM_DELAY_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign init_cd = CD_W'(LATENCY - 1) + CD_W'(lfsr_q[1:0]);

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end
`else
  assign init_cd = CD_W'(LATENCY - 1);
`endif

  always_comb begin
    q_d     = q_q;
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (q_q[i].cd != '0)) q_d[i].cd = q_q[i].cd - 1'b1;
    end

    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = ptr_inc(head_q);
    end

    // Read data is captured at acceptance, so a later write cannot change it.
    if (accept) begin
      q_d[tail_q].is_read = !bus.wr;
      q_d[tail_q].data    = bus.wr ? 32'h0 : rd_word;
      q_d[tail_q].cd      = init_cd;
      vld_d[tail_q]       = 1'b1;
      tail_d              = ptr_inc(tail_q);
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  // Memory is never reset; writes land at the acceptance edge.
  always_ff @(posedge clk) begin
    if (accept && bus.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

endmodule
